ip_cartridge_bus: RTL

Responder for the MSX cartridge slot bus and initiator on the internal VDP register port. It synchronises the asynchronous cartridge strobes (n_ce, n_trd, n_twr, ta, td) into the clk domain and converts each host access into one req/ack transaction. For reads it returns rdata on td, holding the host off with twait until data is ready. It sits between the top-level cartridge pins and the VDP register port.

---
 rtl/ip_cartridge_bus_pkg.sv | 24 ++
 rtl/ip_cartridge_bus_if.sv | 30 +++
 rtl/ip_cart_sync.sv | 30 +++
 rtl/ip_cartridge_bus.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ip_cartridge_bus_pkg.sv
// rtl/ip_cartridge_bus_pkg.sv - shared types and constants for the cartridge slot responder
package ip_cartridge_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_DRIVE,
        WAIT_END
    } state_t;

    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    // Synchroniser lane: {n_ce, n_trd, n_twr, ta[1:0], td_in[7:0]}
    localparam int SYNC_WIDTH = 13;

    // Reset the lane to "all strobes asserted" so nothing arms until real pin values flush through.
    localparam logic [SYNC_WIDTH-1:0] SYNC_RESET_VALUE = '0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ip_cartridge_bus_if.sv
// rtl/ip_cartridge_bus_if.sv - cartridge pins plus VDP register port bundle
interface ip_cartridge_bus_if;

    logic       n_ce;
    logic       n_trd;
    logic       n_twr;
    logic [1:0] ta;
    logic [7:0] td_in;
    logic [7:0] td_out;
    logic       tdir;
    logic       twait;

    logic       req;
    logic       ack;
    logic       wr;
    logic [1:0] address;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport slave (
        input  n_ce, n_trd, n_twr, ta, td_in, ack, rdata,
        output td_out, tdir, twait, req, wr, address, wdata
    );

    modport master (
        output n_ce, n_trd, n_twr, ta, td_in, ack, rdata,
        input  td_out, tdir, twait, req, wr, address, wdata
    );

endinterface

// File: rtl/ip_cart_sync.sv
// rtl/ip_cart_sync.sv - multi-bit flip-flop synchroniser with configurable depth
module ip_cart_sync #(
    parameter int              WIDTH       = 1,
    parameter int              STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RESET_VALUE;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/ip_cartridge_bus.sv
// rtl/ip_cartridge_bus.sv - MSX cartridge slot responder issuing req/ack transactions to the VDP port
module ip_cartridge_bus
    import ip_cartridge_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               reset,
    ip_cartridge_bus_if.slave  bus,
    output wire  [7:0]         td
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

    logic [SYNC_WIDTH-1:0] sync_in;
    logic [SYNC_WIDTH-1:0] sync_out;

    assign sync_in = {bus.n_ce, bus.n_trd, bus.n_twr, bus.ta, bus.td_in};

    ip_cart_sync #(
        .WIDTH       (SYNC_WIDTH),
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (SYNC_RESET_VALUE)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sync_in),
        .q     (sync_out)
    );

    logic       s_ce;
    logic       s_rd;
    logic       s_wr;
    logic [1:0] s_ta;
    logic [7:0] s_td;

    assign s_ce = ~sync_out[12];
    assign s_rd = ~sync_out[11];
    assign s_wr = ~sync_out[10];
    assign s_ta = sync_out[9:8];
    assign s_td = sync_out[7:0];

    logic write_start;
    logic read_start;

    assign write_start = s_ce & s_wr & ~s_rd;
    assign read_start  = s_ce & s_rd & ~s_wr;

    state_t     state,   state_n;
    logic       armed,   armed_n;
    logic       req_r,   req_n;
    logic       wr_r,    wr_n;
    logic [1:0] addr_r,  addr_n;
    logic [7:0] wdata_r, wdata_n;
    logic [7:0] tdo_r,   tdo_n;
    logic       tdir_r,  tdir_n;
    logic       twait_r, twait_n;
    logic [7:0] cnt,     cnt_n;
    logic       timed_out;

    assign timed_out = (cnt == TIMEOUT_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            armed   <= 1'b0;
            req_r   <= 1'b0;
            wr_r    <= 1'b0;
            addr_r  <= 2'd0;
            wdata_r <= 8'd0;
            tdo_r   <= TIMEOUT_RDATA;
            tdir_r  <= 1'b0;
            twait_r <= 1'b0;
            cnt     <= 8'd0;
        end else begin
            state   <= state_n;
            armed   <= armed_n;
            req_r   <= req_n;
            wr_r    <= wr_n;
            addr_r  <= addr_n;
            wdata_r <= wdata_n;
            tdo_r   <= tdo_n;
            tdir_r  <= tdir_n;
            twait_r <= twait_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        armed_n = armed;
        req_n   = req_r;
        wr_n    = wr_r;
        addr_n  = addr_r;
        wdata_n = wdata_r;
        tdo_n   = tdo_r;
        tdir_n  = tdir_r;
        twait_n = twait_r;
        cnt_n   = cnt;

        case (state)
            IDLE: begin
                // After reset, a strobe left over from before must be seen released before we accept anything.
                if (!armed) begin
                    if (!s_rd && !s_wr) begin
                        armed_n = 1'b1;
                    end
                end else if (write_start) begin
                    addr_n  = s_ta;
                    wdata_n = s_td;
                    req_n   = 1'b1;
                    wr_n    = 1'b1;
                    twait_n = 1'b1;
                    cnt_n   = 8'd0;
                    state_n = WR_REQ;
                end else if (read_start) begin
                    addr_n  = s_ta;
                    req_n   = 1'b1;
                    wr_n    = 1'b0;
                    twait_n = 1'b1;
                    tdir_n  = 1'b1;
                    cnt_n   = 8'd0;
                    state_n = RD_REQ;
                end
            end

            WR_REQ: begin
                cnt_n = sat_inc8(cnt);
                if (bus.ack || timed_out) begin
                    req_n   = 1'b0;
                    twait_n = 1'b0;
                    state_n = WAIT_END;
                end
            end

            RD_REQ: begin
                cnt_n = sat_inc8(cnt);
                if (bus.ack) begin
                    tdo_n   = bus.rdata;
                    req_n   = 1'b0;
                    twait_n = 1'b0;
                    state_n = RD_DRIVE;
                end else if (timed_out) begin
                    tdo_n   = TIMEOUT_RDATA;
                    req_n   = 1'b0;
                    twait_n = 1'b0;
                    state_n = RD_DRIVE;
                end
            end

            RD_DRIVE: begin
                if (!s_rd || !s_ce) begin
                    tdir_n  = 1'b0;
                    state_n = IDLE;
                end
            end

            WAIT_END: begin
                if (!s_wr || !s_ce) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.req     = req_r;
    assign bus.wr      = wr_r;
    assign bus.address = addr_r;
    assign bus.wdata   = wdata_r;
    assign bus.td_out  = tdo_r;
    assign bus.tdir    = tdir_r;
    assign bus.twait   = twait_r;

    assign td = tdir_r ? tdo_r : 8'hZZ;

    a_twait_covers_req: assert property (@(posedge clk) disable iff (reset) req_r |-> twait_r);
    a_no_drive_on_write: assert property (@(posedge clk) disable iff (reset) (req_r && wr_r) |-> !tdir_r);

endmodule
